// File: rtl/x1_response_packer_if.sv
// Handshake bundle for the x1 response packer: 35-bit vector input side and byte-stream output side.
interface x1_response_packer_if;
  logic [34:0] po_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  // Environment side: offers vectors, consumes bytes.
  modport master (
    output po_in, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  // Packer side.
  modport slave (
    input  po_in, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/x1_response_packer.sv
// Captures 35-bit x1 output vectors and emits each as five bytes (byte 4 carries a sequence tag),
// while keeping a saturating vector count and a 16-bit MISR over every transmitted byte.
module x1_response_packer #(
  parameter int COUNT_WIDTH = 16,
  parameter bit TAG_EN      = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  x1_response_packer_if.slave    bus,
  output logic [COUNT_WIDTH-1:0] vec_count,
  output logic [15:0]            signature
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]  state;
  logic [34:0] hold;
  logic [4:0]  tag;
  logic [4:0]  tag_cnt;
  logic [2:0]  idx;

  logic        at_last;
  logic        accept;
  logic        xfer;
  logic [7:0]  byte_sel;
  logic [15:0] sig_next;

  assign at_last = (state == SEND) && (idx == 3'd4);

  // in_ready looks at out_ready so a new vector can be taken on the byte-4 transfer without a gap.
  assign bus.in_ready  = (state == IDLE) || (at_last && bus.out_ready);
  assign bus.out_valid = (state == SEND);
  assign bus.out_last  = at_last;
  assign bus.out_data  = byte_sel;

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = bus.out_valid && bus.out_ready;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves byte_sel unassigned (no latch).
    byte_sel = 8'h00;
    if (state == SEND) begin
      case (idx)
        3'd0:    byte_sel = hold[7:0];
        3'd1:    byte_sel = hold[15:8];
        3'd2:    byte_sel = hold[23:16];
        3'd3:    byte_sel = hold[31:24];
        3'd4:    byte_sel = {(TAG_EN ? tag : 5'd0), hold[34:32]};
        default: byte_sel = 8'h00;
      endcase
    end
  end

  assign sig_next = {signature[14:0], signature[15] ^ signature[13] ^ signature[12] ^ signature[10]}
                    ^ {8'h00, byte_sel};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the hold register is reset too, so out_data and byte 4 are defined straight out of reset.
      state     <= IDLE;
      hold      <= '0;
      tag       <= '0;
      tag_cnt   <= '0;
      idx       <= '0;
      vec_count <= '0;
      signature <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
      if (accept) begin
        hold    <= bus.po_in;
        tag     <= tag_cnt;
        tag_cnt <= tag_cnt + 5'd1;
        idx     <= 3'd0;
        state   <= SEND;
      end else if (xfer) begin
        if (at_last) state <= IDLE;
        else         idx   <= idx + 3'd1;
      end

      if (xfer) begin
        signature <= sig_next;
        if (at_last && (vec_count != {COUNT_WIDTH{1'b1}}))
          vec_count <= vec_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_x1_response_packer.sv
// Directed bench for x1_response_packer: a default instance plus a TAG_EN=0, COUNT_WIDTH=4 instance on shared stimulus.
module tb_x1_response_packer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  x1_response_packer_if bus ();
  x1_response_packer_if bus_nt ();

  logic [15:0] count;
  logic [15:0] sig;
  logic [3:0]  count_nt;
  logic [15:0] sig_nt;

  // Model state
  logic [15:0] m_sig;
  logic [15:0] m_sig_nt;
  int          m_cnt;

  always #5 clock = ~clock;

  assign bus_nt.po_in     = bus.po_in;
  assign bus_nt.in_valid  = bus.in_valid;
  assign bus_nt.out_ready = bus.out_ready;

  x1_response_packer dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .vec_count (count),
    .signature (sig)
  );

  x1_response_packer #(.COUNT_WIDTH(4), .TAG_EN(1'b0)) dut_nt (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus_nt),
    .vec_count (count_nt),
    .signature (sig_nt)
  );

  typedef struct packed {
    logic [34:0]      po;
    logic [4:0][7:0]  bytes;  // byte 4 in the top slot
    logic [7:0]       b4_nt;
    logic [4:0][3:0]  stall;  // stall cycles before each byte, byte 4 in the top slot
  } vec_t;

  vec_t tv [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] b);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {8'h00, b};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [34:0] po, input logic [4:0] t, input int i);
    case (i)
      0:       return po[7:0];
      1:       return po[15:8];
      2:       return po[23:16];
      3:       return po[31:24];
      default: return {t, po[34:32]};
    endcase
  endfunction

  function automatic logic [34:0] pat(input int k);
    logic [31:0] lo;
    lo = 32'(k) * 32'h9E37_79B1;
    return {3'(k), lo};
  endfunction

  function automatic logic [3:0] sat15(input int n);
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clock);
    reset    = 1'b0;
    m_sig    = '0;
    m_sig_nt = '0;
    m_cnt    = 0;
  endtask

  task automatic check_idle(input string tag_name);
    check({tag_name, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag_name, "_in_ready"},  bus.in_ready,  1'b1);
    check({tag_name, "_vec_count"}, count,    64'(m_cnt));
    check({tag_name, "_signature"}, sig,      m_sig);
    check({tag_name, "_count_nt"},  count_nt, sat15(m_cnt));
    check({tag_name, "_sig_nt"},    sig_nt,   m_sig_nt);
  endtask

  // One vector through both instances, with per-byte stall cycles.
  task automatic run_vector(input vec_t v);
    logic [7:0] b_nt;
    @(negedge clock);
    bus.po_in     = v.po;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    #1 check("in_ready_idle", bus.in_ready, 1'b1);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.po_in    = ~v.po;
    for (int i = 0; i < 5; i++) begin
      b_nt = (i == 4) ? v.b4_nt : v.bytes[i];
      for (int s = 0; s <= int'(v.stall[i]); s++) begin
        bus.out_ready = (s == int'(v.stall[i]));
        #1;
        check("out_valid", bus.out_valid, 1'b1);
        check("out_data",  bus.out_data,  v.bytes[i]);
        check("out_last",  bus.out_last,  (i == 4));
        check("out_data_nt", bus_nt.out_data, b_nt);
        if (bus.out_ready) begin
          m_sig    = misr(m_sig, v.bytes[i]);
          m_sig_nt = misr(m_sig_nt, b_nt);
        end
        @(negedge clock);
      end
    end
    bus.out_ready = 1'b0;
    m_cnt++;
    #1 check_idle("after_vec");
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] b_nt;
    vec_t       v;

    bus.po_in     = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    m_sig    = '0;
    m_sig_nt = '0;
    m_cnt    = 0;

    tv[0].po = 35'h0;
    tv[0].bytes = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[0].b4_nt = 8'h00;
    tv[0].stall = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    tv[1].po = 35'h1;
    tv[1].bytes = {8'h08, 8'h00, 8'h00, 8'h00, 8'h01};
    tv[1].b4_nt = 8'h00;
    tv[1].stall = {4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
    tv[2].po = 35'h7_89AB_CDEF;
    tv[2].bytes = {8'h17, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    tv[2].b4_nt = 8'h07;
    tv[2].stall = {4'd0, 4'd0, 4'd3, 4'd0, 4'd0};
    tv[3].po = 35'h7_89AB_CDEF;
    tv[3].bytes = {8'h1F, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    tv[3].b4_nt = 8'h07;
    tv[3].stall = {4'd1, 4'd0, 4'd2, 4'd0, 4'd1};

    // Reset state
    #2;
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last",  bus.out_last,  1'b0);
    check("rst_out_data",  bus.out_data,  8'h00);
    check("rst_vec_count", count,         16'h0);
    check("rst_signature", sig,           16'h0);
    apply_reset();

    // Table vectors: zero vector, tag 1, tag 2 with byte-2 stall, tag 3 with scattered stalls
    for (int n = 0; n < 4; n++) run_vector(tv[n]);
    check("tbl_count_hand", count, 16'd4);

    // Back-to-back 40 vectors with out_ready held high; tags wrap 31 -> 0
    apply_reset();
    @(negedge clock);
    bus.po_in     = pat(0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 5; i++) begin
        if (i == 4) begin
          if (k == 39) bus.in_valid = 1'b0;
          else         bus.po_in    = pat(k + 1);
        end
        #1;
        b    = exp_byte(pat(k), 5'(k), i);
        b_nt = exp_byte(pat(k), 5'd0, i);
        check("b2b_out_valid", bus.out_valid, 1'b1);
        check("b2b_out_data",  bus.out_data,  b);
        check("b2b_out_data_nt", bus_nt.out_data, b_nt);
        if (i == 4) check("b2b_in_ready", bus.in_ready, 1'b1);
        m_sig    = misr(m_sig, b);
        m_sig_nt = misr(m_sig_nt, b_nt);
        @(negedge clock);
      end
    end
    bus.out_ready = 1'b0;
    m_cnt = 40;
    #1 check_idle("b2b_end");
    check("b2b_count_hand", count, 16'd40);
    check("b2b_count_nt_sat", count_nt, 4'd15);

    // Reset while byte 2 is pending
    @(negedge clock);
    bus.po_in     = 35'h2_1234_5678;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
    #1 check("stall_b2_data", bus.out_data, 8'h34);
    @(negedge clock);
    #1 check("stall_b2_hold", bus.out_data, 8'h34);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready",  bus.in_ready,  1'b1);
    check("midrst_vec_count", count,         16'h0);
    check("midrst_signature", sig,           16'h0);
    @(negedge clock);
    reset    = 1'b0;
    m_sig    = '0;
    m_sig_nt = '0;
    m_cnt    = 0;

    // Fresh start: tag 0, po=1 -> 01,00,00,00,00 and signature 0x0010
    v.po    = 35'h1;
    v.bytes = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    v.b4_nt = 8'h00;
    v.stall = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    run_vector(v);
    check("fresh_sig_hand",   sig,   16'h0010);
    check("fresh_count_hand", count, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
